// File: rtl/spi_sample_pkg.sv
// Shared opcodes, status-word layout and mode encoding
// for the SPI sample server.
package spi_sample_pkg;

  localparam logic [3:0] OPC_STATUS = 4'h1;
  localparam logic [3:0] OPC_FLUSH  = 4'h2;
  localparam logic [3:0] OPC_STREAM = 4'h3;

  localparam int ST_OVF     = 15;
  localparam int ST_UDF     = 14;
  localparam int ST_MODE    = 13;
  localparam int ST_CNT_MSB = 10;

  typedef enum logic {
    MODE_STATUS = 1'b0,
    MODE_STREAM = 1'b1
  } mode_e;

  function automatic logic [15:0] status_word(
    input logic                  ovf,
    input logic                  udf,
    input mode_e                 mode,
    input logic [ST_CNT_MSB:0]   cnt
  );
    logic [15:0] w;
    w                 = '0;
    w[ST_OVF]         = ovf;
    w[ST_UDF]         = udf;
    w[ST_MODE]        = (mode == MODE_STREAM);
    w[ST_CNT_MSB:0]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/spi_sample_server_fifo.sv
// Show-ahead synchronous FIFO; flush empties it and
// overrides any push or pop in the same cycle.
module sync_fifo #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so full+pop+push is legal
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_sample_server.sv
// Command decoder and TX mux sitting behind a 16-bit SPI
// slave, serving buffered mic samples or a status word.
module spi_sample_server
  import spi_sample_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [15:0]       sample_data,
  input  logic              byteReceived,
  input  logic [15:0]       receivedData,
  input  logic              dataNeeded,
  output logic [15:0]       dataToSend,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  mode_e          mode_q;
  logic           ovf_q;
  logic           udf_q;
  logic           cur_is_sample_q;
  logic [15:0]    head;
  logic [ADDR_W:0] count;
  logic           full;
  logic           empty;
  logic [3:0]     opc;
  logic           is_status;
  logic           is_flush;
  logic           is_stream;
  logic           pop_req;
  logic           pop_ok;
  logic           drop;
  logic           streaming;
  logic           unused_bits;

  assign opc         = receivedData[15:12];
  assign unused_bits = ^receivedData[11:0];
  assign is_status   = byteReceived && (opc == OPC_STATUS);
  assign is_flush    = byteReceived && (opc == OPC_FLUSH);
  assign is_stream   = byteReceived && (opc == OPC_STREAM);
  assign streaming   = (mode_q == MODE_STREAM);

  // Pop only the word the slave actually shifted out as a sample
  assign pop_req = byteReceived && cur_is_sample_q;
  assign pop_ok  = pop_req && !empty;
  assign drop    = sample_valid && full && !pop_ok;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (16),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sample_valid),
    .pop   (pop_req),
    .flush (is_flush),
    .wdata (sample_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign fifo_count = count;
  assign overflow   = ovf_q;

  always_comb begin
    dataToSend = status_word(ovf_q, udf_q, mode_q,
                             (ST_CNT_MSB+1)'(count));
    if (streaming) dataToSend = empty ? 16'h0000 : head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q          <= MODE_STATUS;
      ovf_q           <= 1'b0;
      udf_q           <= 1'b0;
      cur_is_sample_q <= 1'b0;
    end else begin
      if (dataNeeded) cur_is_sample_q <= streaming && !empty;
      if (drop) ovf_q <= 1'b1;
      if (byteReceived && streaming && !cur_is_sample_q)
        udf_q <= 1'b1;
      unique case (1'b1)
        is_status: mode_q <= MODE_STATUS;
        is_stream: mode_q <= MODE_STREAM;
        is_flush: begin
          mode_q <= MODE_STATUS;
          ovf_q  <= 1'b0;
          udf_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_server.sv
// Transaction-level bench for spi_sample_server against a
// queue-based model of the sample server.
module tb_spi_sample_server;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [15:0]       sample_data;
  logic              byteReceived;
  logic [15:0]       receivedData;
  logic              dataNeeded;
  logic [15:0]       dataToSend;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q[$];
  bit          m_stream;
  bit          m_ovf;
  bit          m_udf;

  always #5 clk = ~clk;

  spi_sample_server #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .byteReceived (byteReceived),
    .receivedData (receivedData),
    .dataNeeded   (dataNeeded),
    .dataToSend   (dataToSend),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_tx();
    logic [15:0] w;
    if (m_stream) return (q.size() > 0) ? q[0] : 16'h0000;
    w = 16'h0000;
    w[15] = m_ovf;
    w[14] = m_udf;
    w[13] = m_stream;
    w[10:0] = 11'(q.size());
    return w;
  endfunction

  function automatic void m_push(input logic [15:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  task automatic push(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick;
    sample_valid = 1'b0;
    m_push(d);
  endtask

  // One full SPI word: reload window, 15 shift cycles, completion
  task automatic do_xfer(input string tag,
                         input logic [15:0] cmd,
                         input bit pe,
                         input logic [15:0] pd);
    logic [15:0] exp_tx, tx;
    bit          was_smp;
    exp_tx  = m_tx();
    was_smp = m_stream && (q.size() > 0);
    dataNeeded = 1'b1;
    tick;
    tick;
    tx = dataToSend;
    tick;
    dataNeeded = 1'b0;
    repeat (15) tick;
    dataNeeded   = 1'b1;
    byteReceived = 1'b1;
    receivedData = cmd;
    sample_valid = pe;
    sample_data  = pd;
    tick;
    byteReceived = 1'b0;
    sample_valid = 1'b0;
    receivedData = $urandom;
    if (was_smp) void'(q.pop_front());
    else if (m_stream) m_udf = 1'b1;
    if (pe) m_push(pd);
    case (cmd[15:12])
      4'h1: m_stream = 1'b0;
      4'h2: begin
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_stream = 1'b0;
      end
      4'h3: m_stream = 1'b1;
      default: ;
    endcase
    check({tag, ".tx"}, 32'(tx), 32'(exp_tx));
    check({tag, ".cnt"}, 32'(fifo_count), 32'(q.size()));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    tick;
    dataNeeded = 1'b0;
    tick;
  endtask

  task automatic do_abort(input string tag);
    dataNeeded = 1'b1;
    tick;
    tick;
    dataNeeded = 1'b0;
    repeat (7) tick;
    check({tag, ".cnt"}, 32'(fifo_count), 32'(q.size()));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    q.delete();
    m_stream = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  initial begin
    logic [15:0] cmd;
    int          r;
    sample_valid = 1'b0;
    sample_data  = '0;
    byteReceived = 1'b0;
    receivedData = '0;
    dataNeeded   = 1'b0;
    do_reset;
    check("rst.tx",  32'(dataToSend), 32'h0);
    check("rst.cnt", 32'(fifo_count), 32'h0);
    check("rst.ovf", 32'(overflow),   32'h0);
    do_xfer("nop0", 16'h0000, 0, '0);

    push(16'h1234);
    push(16'hABCD);
    do_xfer("strm", 16'h3000, 0, '0);
    do_xfer("rd0",  16'h0000, 0, '0);
    do_xfer("rd1",  16'h0000, 0, '0);

    do_xfer("udf",  16'h0000, 0, '0);
    do_xfer("stat", 16'h1000, 0, '0);
    do_xfer("stw",  16'h0000, 0, '0);

    for (int i = 0; i < DEPTH + 3; i++) push(16'(16'h0100 + i));
    do_xfer("ovfs", 16'h1000, 0, '0);
    do_xfer("ovst", 16'h3000, 0, '0);
    for (int i = 0; i < DEPTH; i++) do_xfer("ovrd", 16'h0FFF, 0, '0);
    do_xfer("flsh", 16'h2000, 0, '0);
    do_xfer("flst", 16'h0000, 0, '0);

    push(16'h5555);
    push(16'h6666);
    do_xfer("abst", 16'h3000, 0, '0);
    do_abort("abrt");
    do_xfer("abrx", 16'h0000, 0, '0);
    do_xfer("abr2", 16'h2000, 0, '0);

    for (int i = 0; i < DEPTH; i++) push(16'(16'h0A00 + i));
    do_xfer("fst",  16'h3000, 0, '0);
    do_xfer("fpp",  16'h0000, 1, 16'hBEEF);
    for (int i = 0; i < DEPTH; i++) do_xfer("fdr", 16'h0000, 0, '0);
    do_xfer("fend", 16'h2000, 0, '0);

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) push(16'($urandom));
      r = $urandom_range(0, 9);
      cmd = 16'($urandom);
      if (r == 0)      cmd[15:12] = 4'h2;
      else if (r < 3)  cmd[15:12] = 4'h1;
      else if (r < 5)  cmd[15:12] = 4'h3;
      else if (cmd[15:12] inside {4'h1, 4'h2, 4'h3})
        cmd[15:12] = 4'h0;
      if ($urandom_range(0, 7) == 0) do_abort("rab");
      do_xfer("rnd", cmd, ($urandom_range(0, 3) == 0),
              16'($urandom));
    end

    push(16'h7777);
    do_reset;
    tick;
    check("rst2.cnt", 32'(fifo_count), 32'h0);
    check("rst2.tx",  32'(dataToSend), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
